pe_array_dispatch: RTL and testbench

Control plane for the next-generation PE array. It buffers incoming instructions and decodes each into per-PE start pulses, in single-PE, group or broadcast mode. It tracks per-PE busy state so that an instruction is only issued once every PE it targets has finished. It also provides a bounds-checked, registered accumulator-readback mux with a valid strobe. The block sits between the instruction scheduler and the PE instances, generalised over `PE_NUM`, `GRP_SIZE` and FIFO depth.

---
 rtl/pe_array_dispatch_pkg.sv | 71 +++++++
 rtl/pe_array_dispatch_fifo.sv | 64 ++++++
 rtl/pe_array_dispatch.sv | 171 +++++++++++++++++
 tb/tb_pe_array_dispatch.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_array_dispatch_pkg.sv
// Shared types, instruction field layout and helper functions for the PE array dispatcher.
package pe_array_dispatch_pkg;

  // Instruction word and readback geometry.
  localparam int INST_W  = 64;
  localparam int BATCH   = 2;
  localparam int RES_W   = 16;
  localparam int PE_ID_W = 6;
  localparam int CNT_W   = 8;
  localparam int PAD_W   = 4;

  // Bit offsets of every instruction field.
  typedef struct packed {
    int unsigned idx_cnt;
    int unsigned trip_cnt;
    int unsigned pad_code;
    int unsigned pe_id;
    int unsigned is_new;
    int unsigned cut_y;
    int unsigned bcast;
  } ins_const_t;

  localparam ins_const_t INS_CONST = '{
    idx_cnt:  32'd32,
    trip_cnt: 32'd40,
    pad_code: 32'd48,
    pe_id:    32'd52,
    is_new:   32'd58,
    cut_y:    32'd59,
    bcast:    32'd60
  };

  // Fully decoded instruction.
  typedef struct packed {
    logic               bcast;
    logic               cut_y;
    logic               is_new;
    logic [PE_ID_W-1:0] pe_id;
    logic [PAD_W-1:0]   pad_code;
    logic [CNT_W-1:0]   trip_cnt;
    logic [CNT_W-1:0]   idx_cnt;
  } ins_dec_t;

  // Parameters handed to the PEs alongside start.
  typedef struct packed {
    logic [CNT_W-1:0] idx_cnt;
    logic [CNT_W-1:0] trip_cnt;
    logic [PAD_W-1:0] pad_code;
    logic             is_new;
    logic             cut_y;
  } issue_param_t;

  // Global bit-width helper: bits needed to hold the value n itself.
  function automatic int bw(input int unsigned n);
    return (n == 32'd0) ? 1 : $clog2(n + 32'd1);
  endfunction

  // Split an instruction word into its fields.
  function automatic ins_dec_t decode_ins(input logic [INST_W-1:0] ins);
    ins_dec_t d;
    d.idx_cnt  = ins[INS_CONST.idx_cnt  +: CNT_W];
    d.trip_cnt = ins[INS_CONST.trip_cnt +: CNT_W];
    d.pad_code = ins[INS_CONST.pad_code +: PAD_W];
    d.pe_id    = ins[INS_CONST.pe_id    +: PE_ID_W];
    d.is_new   = ins[INS_CONST.is_new];
    d.cut_y    = ins[INS_CONST.cut_y];
    d.bcast    = ins[INS_CONST.bcast];
    return d;
  endfunction

endpackage

// File: rtl/pe_array_dispatch_fifo.sv
// Synchronous instruction FIFO with wrap-around pointers; a written entry is visible at the head one cycle later.
module ins_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full  = (count_r == (AW+1)'(DEPTH));
  assign empty = (count_r == '0);
  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];

  // Qualify requests so a full FIFO never overwrites and an empty one never underflows.
  always_comb begin
    do_push_s = push & ~full;
    do_pop_s  = pop & ~empty;
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      else           wr_ptr_r <= wr_ptr_r;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      else           rd_ptr_r <= rd_ptr_r;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1'b1);
        2'b01:   count_r <= count_r - (AW+1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/pe_array_dispatch.sv
// Instruction dispatcher for the PE array: buffers instructions, issues per-PE start pulses
// once all targeted PEs are free, tracks busy state and provides a registered readback mux.
module pe_array_dispatch
  import pe_array_dispatch_pkg::*;
#(
  parameter int  PE_NUM     = 32,
  parameter int  GRP_SIZE   = 4,
  parameter int  FIFO_DEPTH = 4,
  parameter int  RD_W       = BATCH * RES_W,
  localparam int GRP_NUM    = PE_NUM / GRP_SIZE,
  localparam int SEL_W      = bw(GRP_NUM)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [3:0]                        layer_type,
  input  logic [INST_W-1:0]                 ins,
  input  logic                              ins_valid,
  output logic                              ins_ready,
  input  logic [PE_NUM-1:0]                 done,
  output logic [PE_NUM-1:0]                 start,
  output logic [7:0]                        idx_cnt,
  output logic [7:0]                        trip_cnt,
  output logic [3:0]                        pad_code,
  output logic                              is_new,
  output logic                              cut_y,
  output logic [PE_NUM-1:0]                 busy,
  output logic                              all_idle,
  output logic                              err_pe_id,
  input  logic [SEL_W-1:0]                  rd_sel,
  input  logic                              rd_en,
  input  logic [GRP_NUM*GRP_SIZE*RD_W-1:0]  grp_rd_data,
  output logic [GRP_SIZE*RD_W-1:0]          rd_data,
  output logic                              rd_valid
);

  localparam int SL = GRP_SIZE * RD_W;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [PE_NUM-1:0] ONE_PE   = PE_NUM'(1'b1);
  localparam logic [PE_NUM-1:0] GRP_ONES = PE_NUM'({GRP_SIZE{1'b1}});

  typedef struct packed {
    logic              oor;
    logic [PE_NUM-1:0] mask;
  } target_t;

  // Target mask and range check for one instruction under the given mode.
  function automatic target_t target(input ins_dec_t d, input logic single);
    target_t t;
    t.oor  = 1'b0;
    t.mask = '0;
    if (d.bcast) begin
      t.mask = '1;
    end else if (single) begin
      if (32'(d.pe_id) >= 32'(PE_NUM)) t.oor  = 1'b1;
      else                             t.mask = ONE_PE << d.pe_id;
    end else begin
      if (32'(d.pe_id) >= 32'(GRP_NUM)) t.oor  = 1'b1;
      else                              t.mask = GRP_ONES << (32'(d.pe_id) * 32'(GRP_SIZE));
    end
    return t;
  endfunction

  logic [INST_W-1:0] head_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [CW-1:0]     fifo_count_s;
  ins_dec_t          head_dec_s;
  target_t           tgt_s;
  logic              go_s;
  logic              issue_s;
  logic              drop_s;
  logic [SL-1:0]     rd_mux_s;
  logic              unused_bits_s;

  logic [PE_NUM-1:0] start_r;
  logic [PE_NUM-1:0] busy_r;
  issue_param_t      param_r;
  logic              err_r;
  logic [SL-1:0]     rd_data_r;
  logic              rd_valid_r;

  ins_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (INST_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (ins_valid),
    .push_data (ins),
    .pop       (go_s),
    .head      (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  assign head_dec_s    = decode_ins(head_s);
  assign unused_bits_s = ^{layer_type[3:1], head_s[31:0], head_s[INST_W-1:61]};

  // Dispatch decision: head leaves when its targets are free (done bypassed); out-of-range heads are dropped.
  always_comb begin
    tgt_s = target(head_dec_s, layer_type[0]);
    if (!fifo_empty_s && ((busy_r & ~done & tgt_s.mask) == '0)) begin
      go_s = 1'b1;
    end else begin
      go_s = 1'b0;
    end
    issue_s = go_s & ~tgt_s.oor;
    drop_s  = go_s & tgt_s.oor;
  end

  // Start pulses, busy bitmap, issued parameters and the sticky range-error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_r <= '0;
      busy_r  <= '0;
      param_r <= '0;
      err_r   <= 1'b0;
    end else begin
      start_r <= issue_s ? tgt_s.mask : '0;
      busy_r  <= (busy_r & ~done) | (issue_s ? tgt_s.mask : '0);
      if (issue_s) begin
        param_r.idx_cnt  <= head_dec_s.idx_cnt;
        param_r.trip_cnt <= head_dec_s.trip_cnt;
        param_r.pad_code <= head_dec_s.pad_code;
        param_r.is_new   <= head_dec_s.is_new;
        param_r.cut_y    <= head_dec_s.cut_y;
      end else begin
        param_r <= param_r;
      end
      err_r <= err_r | drop_s;
    end
  end

  // Group select for readback; unselectable groups read as zero.
  always_comb begin
    rd_mux_s = '0;
    for (int g = 0; g < GRP_NUM; g++) begin
      if (rd_sel == SEL_W'(g)) rd_mux_s = grp_rd_data[g*SL +: SL];
      else                     rd_mux_s = rd_mux_s;
    end
  end

  // Registered readback with valid strobe; data holds when not reading.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r  <= '0;
      rd_valid_r <= 1'b0;
    end else if (rd_en) begin
      rd_data_r  <= rd_mux_s;
      rd_valid_r <= 1'b1;
    end else begin
      rd_data_r  <= rd_data_r;
      rd_valid_r <= 1'b0;
    end
  end

  assign ins_ready = ~fifo_full_s;
  assign all_idle  = (fifo_count_s == '0) && (busy_r == '0);
  assign start     = start_r;
  assign busy      = busy_r;
  assign idx_cnt   = param_r.idx_cnt;
  assign trip_cnt  = param_r.trip_cnt;
  assign pad_code  = param_r.pad_code;
  assign is_new    = param_r.is_new;
  assign cut_y     = param_r.cut_y;
  assign err_pe_id = err_r;
  assign rd_data   = rd_data_r;
  assign rd_valid  = rd_valid_r;

endmodule

// File: tb/tb_pe_array_dispatch.sv
// Self-checking bench for pe_array_dispatch: directed sequences, a readback vector table
// and randomized traffic checked every cycle against a queue-based reference model.
module tb_pe_array_dispatch;
  import pe_array_dispatch_pkg::*;

  localparam int PE_NUM     = 32;
  localparam int GRP_SIZE   = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int RD_W       = BATCH * RES_W;
  localparam int GRP_NUM    = PE_NUM / GRP_SIZE;
  localparam int SEL_W      = bw(GRP_NUM);
  localparam int SL         = GRP_SIZE * RD_W;

  logic                             clk;
  logic                             rst;
  logic [3:0]                       layer_type;
  logic [INST_W-1:0]                ins;
  logic                             ins_valid;
  logic                             ins_ready;
  logic [PE_NUM-1:0]                done;
  logic [PE_NUM-1:0]                start;
  logic [7:0]                       idx_cnt;
  logic [7:0]                       trip_cnt;
  logic [3:0]                       pad_code;
  logic                             is_new;
  logic                             cut_y;
  logic [PE_NUM-1:0]                busy;
  logic                             all_idle;
  logic                             err_pe_id;
  logic [SEL_W-1:0]                 rd_sel;
  logic                             rd_en;
  logic [GRP_NUM*GRP_SIZE*RD_W-1:0] grp_rd_data;
  logic [SL-1:0]                    rd_data;
  logic                             rd_valid;

  int checks = 0;
  int errors = 0;

  pe_array_dispatch #(
    .PE_NUM(PE_NUM), .GRP_SIZE(GRP_SIZE), .FIFO_DEPTH(FIFO_DEPTH), .RD_W(RD_W)
  ) dut (
    .clk(clk), .rst(rst), .layer_type(layer_type), .ins(ins), .ins_valid(ins_valid),
    .ins_ready(ins_ready), .done(done), .start(start), .idx_cnt(idx_cnt),
    .trip_cnt(trip_cnt), .pad_code(pad_code), .is_new(is_new), .cut_y(cut_y),
    .busy(busy), .all_idle(all_idle), .err_pe_id(err_pe_id), .rd_sel(rd_sel),
    .rd_en(rd_en), .grp_rd_data(grp_rd_data), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mk(input int pe, input logic [7:0] idx, input logic bc);
    logic [63:0] w;
    w = 64'd0;
    w[39:32] = idx;
    w[47:40] = idx ^ 8'hA5;
    w[51:48] = idx[3:0];
    w[57:52] = 6'(pe);
    w[58]    = idx[0];
    w[59]    = idx[1];
    w[60]    = bc;
    return w;
  endfunction

  task automatic send(input logic [63:0] w);
    bit ok;
    ok = 1'b0;
    ins = w;
    ins_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (ins_ready === 1'b1) ok = 1'b1;
      cyc();
    end
    ins_valid = 1'b0;
    chk("send_accepted", 128'(ok), 128'd1);
  endtask

  // ---------------- reference model ----------------
  logic [63:0]       mq[$];
  logic [PE_NUM-1:0] m_busy, m_start;
  logic [7:0]        m_idx, m_trip;
  logic [3:0]        m_pad;
  logic              m_new, m_cut, m_err, m_rd_valid;
  logic [SL-1:0]     m_rd_data;

  task automatic model_step();
    logic [63:0]       h;
    logic [PE_NUM-1:0] mask;
    bit                oor, blocked, issue, single, bc, tgt;
    bit                can_push;
    int                pe;
    if (rst) begin
      mq.delete();
      m_busy = '0; m_start = '0; m_idx = '0; m_trip = '0; m_pad = '0;
      m_new = 1'b0; m_cut = 1'b0; m_err = 1'b0; m_rd_valid = 1'b0; m_rd_data = '0;
    end else begin
      can_push = (mq.size() < FIFO_DEPTH);
      issue = 1'b0;
      mask = '0;
      if (mq.size() > 0) begin
        h = mq[0];
        pe = int'(h[57:52]);
        bc = h[60];
        single = layer_type[0];
        oor = !bc && (single ? (pe >= PE_NUM) : (pe >= GRP_NUM));
        blocked = 1'b0;
        for (int p = 0; p < PE_NUM; p++) begin
          tgt = !oor && (bc || (single ? (p == pe) : (p / GRP_SIZE == pe)));
          mask[p] = tgt;
          if (tgt && m_busy[p] && !done[p]) blocked = 1'b1;
        end
        if (!blocked) begin
          void'(mq.pop_front());
          if (oor) m_err = 1'b1;
          else begin
            issue = 1'b1;
            m_idx = h[39:32]; m_trip = h[47:40]; m_pad = h[51:48];
            m_new = h[58]; m_cut = h[59];
          end
        end
      end
      for (int p = 0; p < PE_NUM; p++)
        m_busy[p] = (m_busy[p] && !done[p]) || (issue && mask[p]);
      m_start = issue ? mask : '0;
      if (ins_valid && can_push) mq.push_back(ins);
      if (rd_en) begin
        m_rd_valid = 1'b1;
        if (int'(rd_sel) < GRP_NUM) m_rd_data = grp_rd_data[int'(rd_sel)*SL +: SL];
        else                        m_rd_data = '0;
      end else begin
        m_rd_valid = 1'b0;
      end
    end
  endtask

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #2;
      chk("m_start", 128'(start), 128'(m_start));
      chk("m_busy", 128'(busy), 128'(m_busy));
      chk("m_ins_ready", 128'(ins_ready), 128'(mq.size() < FIFO_DEPTH));
      chk("m_all_idle", 128'(all_idle), 128'(mq.size() == 0 && m_busy == '0));
      chk("m_err", 128'(err_pe_id), 128'(m_err));
      chk("m_params", 128'({idx_cnt, trip_cnt, pad_code, is_new, cut_y}),
          128'({m_idx, m_trip, m_pad, m_new, m_cut}));
      chk("m_rd_data", 128'(rd_data), 128'(m_rd_data));
      chk("m_rd_valid", 128'(rd_valid), 128'(m_rd_valid));
    end
  end

  typedef struct {
    logic [SEL_W-1:0] sel;
    logic             en;
    logic             exp_valid;
    logic [SL-1:0]    exp_data;
  } rb_vec_t;

  rb_vec_t rb_tab[6];

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] w;
    logic [3:0]  lt;
    int          pe;

    rb_tab[0] = '{sel: 4'd3,  en: 1'b1, exp_valid: 1'b1, exp_data: 128'h0F0F0F0F_0E0E0E0E_0D0D0D0D_0C0C0C0C};
    rb_tab[1] = '{sel: 4'd8,  en: 1'b1, exp_valid: 1'b1, exp_data: 128'h0};
    rb_tab[2] = '{sel: 4'd0,  en: 1'b1, exp_valid: 1'b1, exp_data: 128'h03030303_02020202_01010101_00000000};
    rb_tab[3] = '{sel: 4'd7,  en: 1'b0, exp_valid: 1'b0, exp_data: 128'h03030303_02020202_01010101_00000000};
    rb_tab[4] = '{sel: 4'd7,  en: 1'b1, exp_valid: 1'b1, exp_data: 128'h1F1F1F1F_1E1E1E1E_1D1D1D1D_1C1C1C1C};
    rb_tab[5] = '{sel: 4'd15, en: 1'b1, exp_valid: 1'b1, exp_data: 128'h0};

    rst = 1'b1; ins_valid = 1'b0; ins = '0; layer_type = 4'd0; done = '0;
    rd_sel = '0; rd_en = 1'b0;
    for (int p = 0; p < PE_NUM; p++) grp_rd_data[p*RD_W +: RD_W] = {4{8'(p)}};
    cyc(); cyc();
    chk("rst_start", 128'(start), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_ready", 128'(ins_ready), 128'd1);
    chk("rst_all_idle", 128'(all_idle), 128'd1);
    chk("rst_err", 128'(err_pe_id), 128'd0);
    chk("rst_rd", 128'({rd_valid, rd_data}), 128'd0);
    chk("rst_idx", 128'({idx_cnt, trip_cnt, pad_code, is_new, cut_y}), 128'd0);
    rst = 1'b0;

    // Single mode, PE 5.
    layer_type = 4'd1;
    send(mk(5, 8'h12, 1'b0));
    chk("single_no_start_yet", 128'(start), 128'd0);
    cyc();
    chk("single_start", 128'(start), 128'h20);
    chk("single_idx", 128'(idx_cnt), 128'h12);
    chk("single_busy", 128'(busy), 128'h20);
    cyc();
    chk("single_start_one_cycle", 128'(start), 128'd0);
    done = 32'h20; cyc(); done = '0;
    chk("single_busy_clear", 128'(busy), 128'd0);
    chk("single_all_idle", 128'(all_idle), 128'd1);

    // Group mode, group 2 twice.
    layer_type = 4'd0;
    send(mk(2, 8'h21, 1'b0));
    send(mk(2, 8'h22, 1'b0));
    chk("grp_start", 128'(start), 128'h0000_0F00);
    chk("grp_idx", 128'(idx_cnt), 128'h21);
    cyc();
    chk("grp_hold_start", 128'(start), 128'd0);
    chk("grp_queued", 128'(all_idle), 128'd0);
    cyc();
    chk("grp_still_blocked", 128'(start), 128'd0);
    done = 32'h0000_0F00; cyc(); done = '0;
    chk("grp_reissue", 128'(start), 128'h0000_0F00);
    chk("grp_reissue_idx", 128'(idx_cnt), 128'h22);
    chk("grp_reissue_busy", 128'(busy), 128'h0000_0F00);
    cyc();
    done = 32'h0000_0F00; cyc(); done = '0;
    chk("grp_idle", 128'(all_idle), 128'd1);

    // Backpressure on busy PE 0.
    layer_type = 4'd1;
    for (int k = 0; k < 5; k++) send(mk(0, 8'(k), 1'b0));
    chk("bp_full", 128'(ins_ready), 128'd0);
    chk("bp_first_idx", 128'(idx_cnt), 128'd0);
    for (int k = 1; k < 5; k++) begin
      done = 32'h1; cyc(); done = '0;
      chk("bp_start", 128'(start), 128'h1);
      chk("bp_idx", 128'(idx_cnt), 128'(k));
      cyc();
    end
    done = 32'h1; cyc(); done = '0;
    chk("bp_drained", 128'(all_idle), 128'd1);

    // Out of range PE id.
    send(mk(40, 8'h40, 1'b0));
    cyc();
    chk("oor_no_start", 128'(start), 128'd0);
    chk("oor_err", 128'(err_pe_id), 128'd1);
    chk("oor_popped", 128'(all_idle), 128'd1);
    send(mk(3, 8'h33, 1'b0));
    cyc();
    chk("oor_next_start", 128'(start), 128'h8);
    chk("oor_next_idx", 128'(idx_cnt), 128'h33);
    chk("oor_err_sticky", 128'(err_pe_id), 128'd1);
    done = 32'h8; cyc(); done = '0;

    // Broadcast, then reset while busy with a queued instruction.
    send(mk(0, 8'h55, 1'b1));
    cyc();
    chk("bc_start", 128'(start), 128'hFFFF_FFFF);
    chk("bc_busy", 128'(busy), 128'hFFFF_FFFF);
    send(mk(0, 8'h56, 1'b1));
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("rst_mid_busy", 128'(busy), 128'd0);
    chk("rst_mid_ready", 128'(ins_ready), 128'd1);
    chk("rst_mid_start", 128'(start), 128'd0);
    chk("rst_mid_err", 128'(err_pe_id), 128'd0);
    cyc(); cyc();
    chk("rst_no_pending_start", 128'(start), 128'd0);
    chk("rst_all_idle", 128'(all_idle), 128'd1);

    // Readback vector table.
    for (int i = 0; i < 6; i++) begin
      rd_sel = rb_tab[i].sel;
      rd_en  = rb_tab[i].en;
      cyc();
      rd_en  = 1'b0;
      chk("rb_valid", 128'(rd_valid), 128'(rb_tab[i].exp_valid));
      chk("rb_data", 128'(rd_data), 128'(rb_tab[i].exp_data));
    end

    // Randomized traffic checked by the model.
    for (int c = 0; c < 3000; c++) begin
      lt = 4'($urandom);
      w  = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) pe = int'($urandom_range(0, 63));
      else pe = lt[0] ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
      w[57:52]   = 6'(pe);
      w[60]      = ($urandom_range(0, 15) == 0);
      layer_type = lt;
      ins        = w;
      ins_valid  = 1'($urandom_range(0, 1));
      done       = $urandom & $urandom & $urandom;
      rd_en      = 1'($urandom_range(0, 1));
      rd_sel     = SEL_W'($urandom);
      rst        = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 15) == 0)
        grp_rd_data[$urandom_range(0, PE_NUM-1)*RD_W +: RD_W] = $urandom;
      cyc();
    end
    rst = 1'b0; ins_valid = 1'b0; done = '0; rd_en = 1'b0;
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
